// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converters: FSM states and
// double-dabble correction constants.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  // Reverse double-dabble: after each right shift, digits >= 8 lose 3.
  localparam logic [BCD_DIGIT_W-1:0] CORR_THRESH = 4'd8;
  localparam logic [BCD_DIGIT_W-1:0] CORR_SUB    = 4'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CORRECT = 2'd2,
    DONE    = 2'd3
  } bcd_state_t;

endpackage

// File: rtl/bcd_digit_corr.sv
// One BCD digit of the reverse double-dabble correction step.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // 8..15 map to 5..12, so the 4-bit result never borrows.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= CORR_THRESH) begin
      digit_o = digit_i - CORR_SUB;
    end
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, shift then correct).
// Optional invalid-digit detection is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 17
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] data_i,
  output logic [BIN_W-1:0]              data_o,
  output logic                          rdy_o,
  output logic                          busy_o,
  output logic                          err_o,
  output bcd_state_t                    dbg_state_o
);

  localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  // Handshake: en is sampled every edge but only accepted in IDLE; rdy_o is a
  // level held from completion until the edge that accepts the next request.
  bcd_state_t         state_q, state_d;
  logic [WORK_W-1:0]  work_q, work_d;
  logic [CNT_W-1:0]   sh_cnt_q, sh_cnt_d;
  logic [BIN_W-1:0]   data_q, data_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;
  logic [BCD_W-1:0]   corr_bcd;

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .digit_i (work_q[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (corr_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic err_lat_q, err_lat_d;
  logic err_q, err_d;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    sh_cnt_d = sh_cnt_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    busy_d   = busy_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    err_lat_d = err_lat_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (en) begin
          work_d   = {data_i, {BIN_W{1'b0}}};
          sh_cnt_d = '0;
          rdy_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          err_lat_d = has_bad_digit(data_i);
          err_d     = 1'b0;
`endif
        end
      end
      SHIFT: begin
        work_d = work_q >> 1;
        if (sh_cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = DONE;
        end else begin
          sh_cnt_d = sh_cnt_q + CNT_W'(1);
          state_d  = CORRECT;
        end
      end
      CORRECT: begin
        work_d  = {corr_bcd, work_q[BIN_W-1:0]};
        state_d = SHIFT;
      end
      DONE: begin
        data_d  = work_q[BIN_W-1:0];
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        err_d = err_lat_q;
        if (err_lat_q) data_d = '0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      sh_cnt_q <= '0;
      data_q   <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_lat_q <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      sh_cnt_q <= sh_cnt_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_lat_q <= err_lat_d;
      err_q     <= err_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign rdy_o       = rdy_q;
  assign busy_o      = busy_q;
  assign dbg_state_o = state_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from every BCD digit ≥ 8. It is the inverse of the binary-to-BCD path feeding the 7-segment display. It converts operator-entered or display-side decimal values back into binary for the arithmetic datapath. It uses the same single-request `en` / level `rdy_o` handshake as the forward converter.

## Interface
- `DIGITS`, default 5: number of packed BCD input digits.
- `BIN_W`, default 17: binary output width. Must satisfy 2^BIN_W > 10^DIGITS − 1.
- `clk` input, 1: single clock; all logic on the rising edge.
- `rst_n` input, 1: synchronous, active-low reset.
- `en` input, 1: start request, sampled each edge; honoured only when idle.
- `data_i` input, 4·DIGITS: packed BCD, digit 0 in bits [3:0].
- `data_o` output, BIN_W: binary result, held until the next completion.
- `rdy_o` output, 1: level flag, high from completion until the next accepted request.
- `busy_o` output, 1: high while a conversion is in flight.
- `err_o` output, 1: invalid-digit flag, valid while `rdy_o` is high (see Configuration).

## Operation
- Working register `work` is {bcd[4·DIGITS−1:0], bin[BIN_W−1:0]}, 4·DIGITS+BIN_W bits. `sh_cnt` counts 0..BIN_W−1.
- State IDLE:
  - If `en` is high at an edge: `work` ← {data_i, 0}, `sh_cnt` ← 0, `rdy_o` ← 0, `busy_o` ← 1, state ← SHIFT.
- State SHIFT:
  - `work` ← `work` >> 1 (logical).
  - If `sh_cnt` == BIN_W−1: state ← DONE.
  - Otherwise: `sh_cnt` ← `sh_cnt`+1, state ← CORRECT.
- State CORRECT: in one cycle, for each digit in parallel, if digit ≥ 8 then digit ← digit − 3. No carry or borrow crosses digit boundaries; the 4-bit result is exact.
- State DONE: `data_o` ← `work`[BIN_W−1:0], `rdy_o` ← 1, `busy_o` ← 0, state ← IDLE.
- `en` in any state other than IDLE is ignored; it is neither queued nor allowed to corrupt `work`.
- `en` held high continuously starts a new conversion every time IDLE is reached.
- Illegal state encoding recovers to IDLE on the next edge.
- After the final shift, the BCD field of `work` is zero for any valid input. The bench checks this as an internal assertion.

## Timing
- Reset values: `data_o`=0, `rdy_o`=0, `busy_o`=0, `err_o`=0, state=IDLE, `work`=0, `sh_cnt`=0.
- Accept edge E0. Shifts occur at E1, E3, …, E(2·BIN_W−1). Corrections occur at E2, …, E(2·BIN_W−2). DONE executes at E(2·BIN_W).
- With defaults, `rdy_o` and `data_o` update at E34: 34 cycles after accept.
- Back-to-back throughput: one result per 2·BIN_W+1 cycles.
- `rdy_o` falls on the accept edge of the next request. In that same cycle, `data_o` keeps its old value.
- `rst_n` low during any state aborts the conversion at that edge:
  - All outputs return to reset values.
  - No `rdy_o` pulse is produced for the aborted request.
- `rst_n` low takes priority over `en` in the same cycle.

## Configuration
- `BCD2BIN_DIGIT_CHECK_EN` defined:
  - At accept, `err` is latched if any `data_i` nibble is > 9.
  - The conversion still runs with identical timing.
  - At DONE, `err_o` ← latched `err`. If it is set, `data_o` ← 0.
  - `err_o` clears with `rdy_o` on the next accept.
- `BCD2BIN_DIGIT_CHECK_EN` undefined:
  - `err_o` is tied to 0 and there is no check logic.
  - `data_o` for invalid digits is deterministic but unspecified; the bench does not check it.

## Structure
- Package `bcd_pkg` holds:
  - the state typedef (IDLE, SHIFT, CORRECT, DONE);
  - `BCD_DIGIT_W`=4;
  - the correction constants: threshold 8, subtrahend 3.
- The forward converter uses the same package.
- Sub-module `bcd_digit_corr`: combinational 4-bit, digit ≥ 8 → digit − 3. It is instantiated DIGITS times via generate in the CORRECT path.

## Test plan
- Reset then `data_i`=0x12345 with `en` pulse → at E34, `rdy_o`=1, `data_o`=0x03039, `busy_o`=0.
- `data_i`=0x99999 → `data_o`=0x1869F. `data_i`=0x00000 → `data_o`=0, `rdy_o`=1.
- Accept 0x00042, then pulse `en` with 0x00099 at E5 → single result 0x0002A at E34; `busy_o` high for E1..E33.
- `rst_n`=0 at E10 of a conversion of 0x54321 → all outputs 0, no `rdy_o` for that request. Then 0x65535 → `data_o`=0x0FFFF at E34 after its accept.
- Macro defined, `data_i`=0x1A345 → `rdy_o`=1, `err_o`=1, `data_o`=0. Next valid 0x00007 → `err_o`=0, `data_o`=7.
- `en` held high with 0x00010 → `rdy_o` rises every 35 cycles with `data_o`=0x0000A. `rdy_o` falls on each re-accept edge.
